bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/lsu_types.sv | 23 ++
 rtl/sp_byte_ram.sv | 36 +++
 rtl/bus_mem_responder.sv | 118 +++++++++++
 tb/tb_bus_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_types.sv
// Bus types shared between the LSU and its memory-side responders.
// One request struct and one response struct carry the whole handshake.
package lsu_types;

    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_BE = BUS_DW / 8;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [31:0]       addr;
        logic [BUS_BE-1:0] wstrb;
        logic [BUS_DW-1:0] wdata;
        logic              rready;
    } cache_bus_req_t;

    typedef struct packed {
        logic              ready;
        logic              data_ok;
        logic [BUS_DW-1:0] rdata;
    } cache_bus_resp_t;

endpackage

// File: rtl/sp_byte_ram.sv
// Single-port synchronous RAM with per-byte write enables.
// Read data is registered and only refreshed on a read access (en with we == 0).
module sp_byte_ram
    import lsu_types::*;
#(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [BUS_BE-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rdata
);

    logic [BUS_DW-1:0] mem_q [WORDS];
    logic [BUS_DW-1:0] rdata_q;

    // No reset: contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(BUS_BE); i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == '0) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-backed responder for the LSU bus: accepts one request at a time,
// waits LATENCY cycles, performs the access and holds the response until rready.
module bus_mem_responder
    import lsu_types::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = 4;

    // Handshake: a request is taken on any clock edge where valid && ready;
    // ready is high only in IDLE. The response is held while data_ok && !rready
    // and retires on the edge where data_ok && rready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic [BUS_BE-1:0] wstrb_q, wstrb_d;
    logic [BUS_DW-1:0] wdata_q, wdata_d;

    logic              mem_en;
    logic [BUS_BE-1:0] mem_we;
    logic [BUS_DW-1:0] mem_rdata;
    logic              unused_addr_bits;

    // Upper address bits wrap and the byte offset is ignored.
    assign unused_addr_bits = ^{bus_req_i.addr[31:AW+2], bus_req_i.addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        widx_d  = widx_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        mem_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_req_i.valid) begin
                    write_d = bus_req_i.write;
                    widx_d  = bus_req_i.addr[AW+1:2];
                    wstrb_d = bus_req_i.wstrb;
                    wdata_d = bus_req_i.wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Gated by rst_n so a reset on the access edge drops a pending write.
                    mem_en  = rst_n;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus_req_i.rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            widx_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            widx_q  <= widx_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we = write_q ? wstrb_q : '0;

    sp_byte_ram #(
        .WORDS(MEM_WORDS),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (widx_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        bus_resp_o         = '0;
        bus_resp_o.ready   = (state_q == IDLE);
        bus_resp_o.data_ok = (state_q == RESP);
        bus_resp_o.rdata   = (state_q == RESP && !write_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder with a transaction-level reference model
// compared against the DUT outputs on every cycle after the first reset.
module tb_bus_mem_responder;
    import lsu_types::*;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned LATENCY   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    cache_bus_req_t  req;
    cache_bus_resp_t resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_req_i (req),
        .bus_resp_o(resp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, response LATENCY edges after accept.
    bit                m_on = 1'b0;
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    int                m_left = 0;
    bit                m_wr = 1'b0;
    int unsigned       m_idx = 0;
    logic [3:0]        m_strb = '0;
    logic [31:0]       m_wd = '0;
    logic [31:0]       m_rd = '0;
    logic [31:0]       m_cur;
    logic [31:0]       mem_m [int unsigned];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on   = 1'b1;
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_left = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (req.valid) begin
                    m_busy = 1'b1;
                    m_wr   = req.write;
                    m_idx  = (req.addr >> 2) % MEM_WORDS;
                    m_strb = req.wstrb;
                    m_wd   = req.wdata;
                    m_left = LATENCY;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_resp = 1'b1;
                    m_cur  = mem_m.exists(m_idx) ? mem_m[m_idx] : 32'h0;
                    if (m_wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_strb[b]) m_cur[8*b +: 8] = m_wd[8*b +: 8];
                        end
                        if (m_strb != 4'h0) mem_m[m_idx] = m_cur;
                        m_rd = 32'h0;
                    end else begin
                        m_rd = m_cur;
                    end
                end
            end else if (m_resp && req.rready) begin
                m_resp = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("ready", {31'b0, resp.ready}, {31'b0, !m_busy});
            chk("data_ok", {31'b0, resp.data_ok}, {31'b0, m_resp});
            chk("rdata", resp.rdata, (m_resp && !m_wr) ? m_rd : 32'h0);
        end
    end

    // Drive a request and return just after the accept edge, scrambling the bus.
    task automatic start(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd, input logic rr);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        req.valid  = 1'b1;
        req.write  = wr;
        req.addr   = addr;
        req.wstrb  = strb;
        req.wdata  = wd;
        req.rready = rr;
        @(negedge clk);
        while (!resp.ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!resp.ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req.valid = 1'b0;
        req.write = ~wr;
        req.addr  = ~addr;
        req.wstrb = ~strb;
        req.wdata = ~wd;
    endtask

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output int lat);
        start(wr, addr, strb, wd, hold == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp.data_ok && lat < 40);
        if (!resp.data_ok) chk("resp_timeout", 32'd0, 32'd1);
        rd = resp.rdata;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data_ok", {31'b0, resp.data_ok}, 32'd1);
            chk("hold_rdata", resp.rdata, rd);
            chk("hold_ready", {31'b0, resp.ready}, 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            req.rready = 1'b1;
        end
        @(posedge clk); #1;
        req.rready = 1'b0;
        @(negedge clk);
        chk("idle_after_hs", {31'b0, resp.ready}, 32'd1);
    endtask

    logic [31:0] rd;
    int          lat;
    int          acc [3];
    int          n;
    int          g;

    initial begin
        req   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, resp.ready}, 32'd1);
        chk("reset_data_ok", {31'b0, resp.data_ok}, 32'd0);
        chk("reset_rdata", resp.rdata, 32'h0);

        // Preload word 4, then read it back.
        txn(1'b1, 32'h0000_0010, 4'hF, 32'h0404_A5A5, 0, rd, lat);
        chk("write_rdata_zero", rd, 32'h0);
        txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, rd, lat);
        chk("read_latency", lat, 32'd3);
        chk("read_word4", rd, 32'h0404_A5A5);

        // Byte-lane merge.
        txn(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 0, rd, lat);
        txn(1'b1, 32'h0000_0020, 4'b0101, 32'hDEAD_BEEF, 0, rd, lat);
        txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 0, rd, lat);
        chk("merge_read", rd, 32'h11AD_33EF);

        // Back-pressure: rready low for 5 response cycles.
        txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 5, rd, lat);
        chk("hold_read", rd, 32'h11AD_33EF);

        // Zero strobe completes without changing memory.
        txn(1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 0, rd, lat);
        txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 0, rd, lat);
        chk("zero_strb_read", rd, 32'h11AD_33EF);

        // Address wrap and ignored byte offset.
        txn(1'b1, 32'h4000_0040, 4'hF, 32'hCAFE_F00D, 0, rd, lat);
        txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, rd, lat);
        chk("wrap_read", rd, 32'hCAFE_F00D);
        txn(1'b0, 32'h0000_0043, 4'hF, 32'h0, 0, rd, lat);
        chk("offset_read", rd, 32'hCAFE_F00D);

        // Valid held high across three reads.
        @(posedge clk); #1;
        req.valid  = 1'b1;
        req.write  = 1'b0;
        req.addr   = 32'h0000_0010;
        req.rready = 1'b1;
        n = 0;
        g = 0;
        while (n < 3 && g < 60) begin
            @(negedge clk);
            g++;
            if (resp.ready) begin
                acc[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
        chk("b2b_accepts", n, 32'd3);
        chk("b2b_gap1", acc[1] - acc[0], 32'd4);
        chk("b2b_gap2", acc[2] - acc[1], 32'd4);
        repeat (6) @(posedge clk);
        #1 req.rready = 1'b0;

        // Reset while a write waits: memory keeps the old word.
        txn(1'b1, 32'h0000_0030, 4'hF, 32'h5566_7788, 0, rd, lat);
        start(1'b1, 32'h0000_0030, 4'hF, 32'h9999_9999, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wait_data_ok", {31'b0, resp.data_ok}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wait_ready", {31'b0, resp.ready}, 32'd1);
        txn(1'b0, 32'h0000_0030, 4'hF, 32'h0, 0, rd, lat);
        chk("rst_wait_old_data", rd, 32'h5566_7788);

        // Reset while a response is held: no further response.
        start(1'b0, 32'h0000_0030, 4'hF, 32'h0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!resp.data_ok && g < 40);
        chk("rst_resp_seen", {31'b0, resp.data_ok}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_resp_dropped", {31'b0, resp.data_ok}, 32'd0);
        end

        // Contents survive reset.
        txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, rd, lat);
        chk("mem_kept", rd, 32'h0404_A5A5);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
